// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory port: write_mem / read_mem codes used by
// both the pipeline controller and the responder, plus the responder FSM states.
package dmem_pkg;

  // write_mem field
  localparam logic [1:0] WM_NONE = 2'b00;
  localparam logic [1:0] WM_SB   = 2'b01;
  localparam logic [1:0] WM_SH   = 2'b10;
  localparam logic [1:0] WM_SW   = 2'b11;

  // read_mem field; 3'b110 and 3'b111 behave as none
  localparam logic [2:0] RM_NONE = 3'b000;
  localparam logic [2:0] RM_LB   = 3'b001;
  localparam logic [2:0] RM_LBU  = 3'b010;
  localparam logic [2:0] RM_LH   = 3'b011;
  localparam logic [2:0] RM_LHU  = 3'b100;
  localparam logic [2:0] RM_LW   = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Request fields captured at the accept edge
  typedef struct packed {
    logic [1:0]  write_mem;
    logic [2:0]  read_mem;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle of the data-memory port. The pipeline MEM stage is
// the master; data_mem_responder is the slave.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_write_mem;
  logic [2:0]  req_read_mem;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_write_mem, req_read_mem,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_write_mem, req_read_mem,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the data-memory port.
// Store path: byte enables and replicated write word. Load path: lane extract
// and sign/zero extension. Build option DMEM_MISALIGN_TRAP_EN turns on the
// misalignment fault; without it low address bits are masked to alignment.
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  write_mem_i,
  input  logic [2:0]  read_mem_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic        is_store;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // A nonzero write field wins over any read field
  assign is_store = (write_mem_i != WM_NONE);
  assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

  // Store path: pick byte enables, replicate data across lanes
  always_comb begin
    // NOTE: default every output first so no path leaves a latch behind.
    be_o    = 4'b0000;
    wword_o = '0;
    case (write_mem_i)
      WM_SB: begin
        be_o    = 4'b0001 << addr_lo_i;
        wword_o = {4{wdata_i[7:0]}};
      end
      WM_SH: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
      end
      WM_SW: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
      end
      default: ;
    endcase
  end

  // Load path: extract lane and extend; stores and none return zero
  always_comb begin
    rdata_o = '0;
    if (!is_store) begin
      case (read_mem_i)
        RM_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
        RM_LBU:  rdata_o = {24'b0, byte_sel};
        RM_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
        RM_LHU:  rdata_o = {16'b0, half_sel};
        RM_LW:   rdata_o = rword_i;
        default: ;
      endcase
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  // Fault on halves at odd addresses and words off a 4-byte boundary
  always_comb begin
    misalign_o = 1'b0;
    if (is_store) begin
      misalign_o = ((write_mem_i == WM_SH) && addr_lo_i[0]) ||
                   ((write_mem_i == WM_SW) && (addr_lo_i != 2'b00));
    end else begin
      case (read_mem_i)
        RM_LH, RM_LHU: misalign_o = addr_lo_i[0];
        RM_LW:         misalign_o = |addr_lo_i;
        default:       ;
      endcase
    end
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers
// LATENCY edges after the accept edge. req_ready low stalls the MEM stage.
// Optional build macro: DMEM_MISALIGN_TRAP_EN (misalignment fault on rsp_err).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2    // 1..15
) (
  input  logic                clk,
  input  logic                rst,
  data_mem_responder_if.slave bus
);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] rdata_q;
  logic        err_q;
  dmem_req_t   req_q;

  logic              accept;
  logic              access;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rword;
  logic [31:0]       wword;
  logic [31:0]       ext;
  logic [3:0]        be;
  logic              misalign;
  logic [31:0]       rdata_d;
  logic              err_d;

  logic [31:0] mem [0:2**ADDR_W-1];

  // Upper address bits are ignored: addresses wrap modulo the array size
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_q.addr[31:ADDR_W+2];

  assign bus.req_ready = ready_q & ~rst;
  assign accept        = bus.req_valid & bus.req_ready;
  assign access        = (state_q == WAIT) && (cnt_q == 4'd0);
  assign idx           = req_q.addr[ADDR_W+1:2];
  assign rword         = mem[idx];

  mem_lane_align u_align (
    .write_mem_i (req_q.write_mem),
    .read_mem_i  (req_q.read_mem),
    .addr_lo_i   (req_q.addr[1:0]),
    .wdata_i     (req_q.wdata),
    .rword_i     (rword),
    .be_o        (be),
    .wword_o     (wword),
    .rdata_o     (ext),
    .misalign_o  (misalign)
  );

  assign err_d   = misalign;
  assign rdata_d = misalign ? 32'h0 : ext;

  assign bus.rsp_valid = valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Capture request fields at accept; the initiator may change them afterwards
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q <= '{write_mem: bus.req_write_mem, read_mem: bus.req_read_mem,
                 addr: bus.req_addr, wdata: bus.req_wdata};
    end
  end

  // Responder FSM with registered ready/valid/data outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            state_q <= WAIT;
            cnt_q   <= 4'(LATENCY - 1);
            ready_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= RESP;
            ready_q <= 1'b1;
            valid_q <= 1'b1;
            rdata_q <= rdata_d;
            err_q   <= err_d;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Byte-enabled array write on the access edge; faults and reset block it
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents survive rst by design.
    if (!rst && access && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a table of requests with
// expected responses fed through a driver, a scoreboard queue checked by a
// monitor, and hand-written back-to-back and reset-mid-operation sequences.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if bus_if ();

  data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [1:0]  wm;
    logic [2:0]  rm;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   resp_cyc[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] wm, input logic [2:0] rm,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.wm = wm; v.rm = rm; v.addr = a; v.wdata = d; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // Monitor: sample 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("rsp_valid_in_reset", 32'(bus_if.rsp_valid), 32'd0);
      check("req_ready_in_reset", 32'(bus_if.req_ready), 32'd0);
    end else if (bus_if.rsp_valid) begin
      check("req_ready_in_resp", 32'(bus_if.req_ready), 32'd1);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
      end else begin
        e = sb.pop_front();
        check($sformatf("rdata[%0d]", e.id), bus_if.rsp_rdata, e.rdata);
        check($sformatf("err[%0d]", e.id), 32'(bus_if.rsp_err), 32'(e.err));
        check($sformatf("latency[%0d]", e.id), 32'(cyc - e.acc), 32'(LATENCY));
        resp_cyc.push_back(cyc);
      end
    end else if (sb.size() != 0 && cyc > sb[0].acc) begin
      check("req_ready_in_wait", 32'(bus_if.req_ready), 32'd0);
    end
  end

  // Drive one request from a falling edge; returns at the falling edge after accept
  task automatic issue(input vec_t v, input int id, output bit in_resp);
    int waited = 0;
    bus_if.req_valid     = 1'b1;
    bus_if.req_write_mem = v.wm;
    bus_if.req_read_mem  = v.rm;
    bus_if.req_addr      = v.addr;
    bus_if.req_wdata     = v.wdata;
    while (!bus_if.req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    in_resp = bus_if.rsp_valid;
    if (!bus_if.req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout[%0d]: req_ready=0, required 1", id);
      bus_if.req_valid = 1'b0;
    end else begin
      sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, acc: cyc + 1, id: id});
    end
    @(negedge clk);
  endtask

  // Drop valid and scramble the other inputs, which must be ignored now
  task automatic idle();
    bus_if.req_valid     = 1'b0;
    bus_if.req_addr      = $urandom;
    bus_if.req_wdata     = $urandom;
    bus_if.req_write_mem = 2'($urandom_range(0, 3));
    bus_if.req_read_mem  = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  vec_t tbl[$];
  bit   inr, r1, r2, r3;

  initial begin
    idle();

    // Load/store table; expected values worked out by hand for ADDR_W=10
    tbl.push_back(mk(WM_SW,   RM_NONE, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0));
    tbl.push_back(mk(WM_NONE, RM_LW,   32'h10,   32'h0,        32'hDEADBEEF, 1'b0));
    tbl.push_back(mk(WM_SB,   RM_NONE, 32'h13,   32'h12345680, 32'h0,        1'b0));
    tbl.push_back(mk(WM_NONE, RM_LB,   32'h13,   32'h0,        32'hFFFFFF80, 1'b0));
    tbl.push_back(mk(WM_NONE, RM_LBU,  32'h13,   32'h0,        32'h00000080, 1'b0));
    tbl.push_back(mk(WM_NONE, RM_LW,   32'h10,   32'h0,        32'h80ADBEEF, 1'b0));
    tbl.push_back(mk(WM_SH,   RM_NONE, 32'h12,   32'hABCD8001, 32'h0,        1'b0));
    tbl.push_back(mk(WM_NONE, RM_LH,   32'h12,   32'h0,        32'hFFFF8001, 1'b0));
    tbl.push_back(mk(WM_NONE, RM_LHU,  32'h12,   32'h0,        32'h00008001, 1'b0));
    tbl.push_back(mk(WM_NONE, RM_LW,   32'h10,   32'h0,        32'h8001BEEF, 1'b0));
    tbl.push_back(mk(WM_NONE, RM_LB,   32'h10,   32'h0,        32'hFFFFFFEF, 1'b0));
    tbl.push_back(mk(WM_NONE, RM_LBU,  32'h11,   32'h0,        32'h000000BE, 1'b0));
    tbl.push_back(mk(WM_NONE, RM_LH,   32'h10,   32'h0,        32'hFFFFBEEF, 1'b0));
    tbl.push_back(mk(WM_NONE, RM_NONE, 32'h10,   32'h0,        32'h0,        1'b0));
    tbl.push_back(mk(WM_SW,   RM_LW,   32'h18,   32'h00000077, 32'h0,        1'b0));
    tbl.push_back(mk(WM_NONE, RM_LW,   32'h18,   32'h0,        32'h00000077, 1'b0));
    tbl.push_back(mk(WM_NONE, 3'b110,  32'h10,   32'h0,        32'h0,        1'b0));
    tbl.push_back(mk(WM_NONE, RM_LW,   32'h1010, 32'h0,        32'h8001BEEF, 1'b0));
    tbl.push_back(mk(WM_SW,   RM_NONE, 32'h1014, 32'h11112222, 32'h0,        1'b0));
    tbl.push_back(mk(WM_NONE, RM_LW,   32'h14,   32'h0,        32'h11112222, 1'b0));
    tbl.push_back(mk(WM_SW,   RM_NONE, 32'h20,   32'hCAFEF00D, 32'h0,        1'b0));

    // Power-on reset
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus_if.rsp_rdata, 32'h0);
    check("reset_rsp_err",   32'(bus_if.rsp_err), 32'd0);
    check("reset_req_ready", 32'(bus_if.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(bus_if.req_ready), 32'd1);
    @(negedge clk);

    // Table-driven single requests
    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i], i, inr);
      idle();
      drain();
    end

    // Back-to-back: valid held high across three loads
    resp_cyc.delete();
    issue(mk(WM_NONE, RM_LW,  32'h10, 32'h0, 32'h8001BEEF, 1'b0), 50, r1);
    issue(mk(WM_NONE, RM_LBU, 32'h12, 32'h0, 32'h00000001, 1'b0), 51, r2);
    issue(mk(WM_NONE, RM_LW,  32'h14, 32'h0, 32'h11112222, 1'b0), 52, r3);
    idle();
    drain();
    check("b2b_accept2_in_resp", 32'(r2), 32'd1);
    check("b2b_accept3_in_resp", 32'(r3), 32'd1);
    check("b2b_resp_count", 32'(resp_cyc.size()), 32'd3);
    if (resp_cyc.size() == 3) begin
      check("b2b_spacing_1", 32'(resp_cyc[1] - resp_cyc[0]), 32'(LATENCY + 1));
      check("b2b_spacing_2", 32'(resp_cyc[2] - resp_cyc[1]), 32'(LATENCY + 1));
    end

    // Reset in WAIT of a store: the store must be dropped
    issue(mk(WM_SW, RM_NONE, 32'h20, 32'h00001234, 32'h0, 1'b0), 60, inr);
    rst = 1'b1;
    sb.delete();
    idle();
    repeat (3) @(negedge clk);
    check("midrst_req_ready", 32'(bus_if.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_midrst", 32'(bus_if.req_ready), 32'd1);
    check("valid_after_midrst", 32'(bus_if.rsp_valid), 32'd0);
    @(negedge clk);
    issue(mk(WM_NONE, RM_LW, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0), 61, inr);
    idle();
    drain();

    // Misaligned accesses
`ifdef DMEM_MISALIGN_TRAP_EN
    issue(mk(WM_NONE, RM_LW,  32'h22, 32'h0,        32'h0,        1'b1), 70, inr); idle(); drain();
    issue(mk(WM_SW,   RM_NONE,32'h22, 32'h00005555, 32'h0,        1'b1), 71, inr); idle(); drain();
    issue(mk(WM_NONE, RM_LW,  32'h20, 32'h0,        32'hCAFEF00D, 1'b0), 72, inr); idle(); drain();
    issue(mk(WM_NONE, RM_LH,  32'h11, 32'h0,        32'h0,        1'b1), 73, inr); idle(); drain();
    issue(mk(WM_NONE, RM_LHU, 32'h13, 32'h0,        32'h0,        1'b1), 74, inr); idle(); drain();
`else
    issue(mk(WM_NONE, RM_LW,  32'h22, 32'h0,        32'hCAFEF00D, 1'b0), 70, inr); idle(); drain();
    issue(mk(WM_SW,   RM_NONE,32'h22, 32'h00005555, 32'h0,        1'b0), 71, inr); idle(); drain();
    issue(mk(WM_NONE, RM_LW,  32'h20, 32'h0,        32'h00005555, 1'b0), 72, inr); idle(); drain();
    issue(mk(WM_NONE, RM_LH,  32'h11, 32'h0,        32'hFFFFBEEF, 1'b0), 73, inr); idle(); drain();
    issue(mk(WM_NONE, RM_LHU, 32'h13, 32'h0,        32'h00008001, 1'b0), 74, inr); idle(); drain();
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
